// File: rtl/div_seq.sv
// div_seq: iterative restoring divider, one quotient bit per clock.
// Shares the cal/rdy handshake of the shift-add multiplier so the two are
// interchangeable in a datapath. Define DIV_SIGNED_EN for two's-complement
// operands; this adds a FIX state that applies the result signs.
module div_seq #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cal,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] q,
   output logic [W-1:0] r,
   output logic         dz,
   output logic         rdy
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  ctr_q, ctr_d;
   logic [W-1:0]   rem_q, rem_d;
   logic [W-1:0]   quo_q, quo_d;
   logic [W-1:0]   div_q, div_d;
   logic [W-1:0]   q_q, q_d;
   logic [W-1:0]   r_q, r_d;
   logic           dz_q, dz_d;
   logic           rdy_q, rdy_d;
`ifdef DIV_SIGNED_EN
   logic           sa_q, sa_d;
   logic           sb_q, sb_d;
`endif

   logic [W-1:0]   mag_a;
   logic [W-1:0]   mag_b;
   logic [W:0]     shifted;
   logic           fits;
   logic [W-1:0]   step_rem;
   logic [W-1:0]   step_quo;
   logic           last_step;

   // Operand magnitudes fed into the unsigned core, plus one restoring step
   always_comb begin
`ifdef DIV_SIGNED_EN
      mag_a = a[W-1] ? -a : a;
      mag_b = b[W-1] ? -b : b;
`else
      mag_a = a;
      mag_b = b;
`endif
      shifted   = {rem_q, quo_q[W-1]};
      fits      = (shifted >= {1'b0, div_q});
      step_rem  = fits ? (shifted[W-1:0] - div_q) : shifted[W-1:0];
      step_quo  = {quo_q[W-2:0], fits};
      last_step = (ctr_q == CW'(1));
   end

   // State and datapath registers; synchronous reset wins over everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ctr_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         div_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dz_q    <= 1'b0;
         rdy_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ctr_q   <= ctr_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         div_q   <= div_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dz_q    <= dz_d;
         rdy_q   <= rdy_d;
`ifdef DIV_SIGNED_EN
         sa_q    <= sa_d;
         sb_q    <= sb_d;
`endif
      end
   end

   // Next-state: accept in IDLE, run W steps, optionally fix signs
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (cal) state_d = CALC;
         CALC: begin
            if (last_step) begin
`ifdef DIV_SIGNED_EN
               state_d = FIX;
`else
               state_d = IDLE;
`endif
            end
         end
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and result updates for each state
   always_comb begin
      ctr_d = ctr_q;
      rem_d = rem_q;
      quo_d = quo_q;
      div_d = div_q;
      q_d   = q_q;
      r_d   = r_q;
      dz_d  = dz_q;
      rdy_d = rdy_q;
`ifdef DIV_SIGNED_EN
      sa_d  = sa_q;
      sb_d  = sb_q;
`endif
      case (state_q)
         IDLE: begin
            if (cal) begin
               rem_d = '0;
               quo_d = mag_a;
               div_d = mag_b;
               ctr_d = CW'(W);
               rdy_d = 1'b0;
               dz_d  = (b == '0);
`ifdef DIV_SIGNED_EN
               sa_d  = a[W-1];
               sb_d  = b[W-1];
`endif
            end
         end
         CALC: begin
            rem_d = step_rem;
            quo_d = step_quo;
            ctr_d = ctr_q - CW'(1);
`ifndef DIV_SIGNED_EN
            if (last_step) begin
               q_d   = step_quo;
               r_d   = step_rem;
               rdy_d = 1'b1;
            end
`endif
         end
`ifdef DIV_SIGNED_EN
         FIX: begin
            if (dz_q) q_d = '1;
            else      q_d = (sa_q ^ sb_q) ? -quo_q : quo_q;
            r_d   = sa_q ? -rem_q : rem_q;
            rdy_d = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // Result ports; rdy is masked by a new request in the same cycle
   always_comb begin
      q   = q_q;
      r   = r_q;
      dz  = dz_q;
      rdy = rdy_q & ~cal;
   end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: self-checking bench for div_seq (W=8), directed cases plus
// randomized operands compared with an arithmetic reference model.
// Honours DIV_SIGNED_EN in the same way as the design.
module tb_div_seq;

   localparam int W = 8;
`ifdef DIV_SIGNED_EN
   localparam int LAT = W + 1;
`else
   localparam int LAT = W;
`endif

   logic         clk;
   logic         rst;
   logic         cal;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] q;
   logic [W-1:0] r;
   logic         dz;
   logic         rdy;

   int           total;
   int           bad;
   logic [W-1:0] prev_q;

   div_seq #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .cal (cal),
      .a   (a),
      .b   (b),
      .q   (q),
      .r   (r),
      .dz  (dz),
      .rdy (rdy)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single point of comparison: counts and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: plain division, with the divide-by-zero convention
   function automatic void refModel(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                    output logic [W-1:0] eq, output logic [W-1:0] er,
                                    output logic edz);
      int sa;
      int sb;
      edz = (tb_ == '0);
      if (edz) begin
         eq = '1;
         er = ta;
      end else begin
`ifdef DIV_SIGNED_EN
         sa = int'($signed(ta));
         sb = int'($signed(tb_));
`else
         sa = int'(ta);
         sb = int'(tb_);
`endif
         eq = W'(sa / sb);
         er = W'(sa % sb);
      end
   endfunction

   // Wait for rdy, bounded; also checks q holds during the calculation
   task automatic waitResult(output int cycles);
      cycles = 0;
      while (cycles < 4 * LAT) begin
         @(posedge clk);
         #1;
         cycles++;
         if (cycles == 1) checkOutput("hold_q", q, prev_q);
         if (rdy) break;
      end
      if (!rdy) checkOutput("timeout_rdy", rdy, 1);
   endtask

   // One full operation with 1-cycle cal; called #1 after a rising edge
   task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb_);
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic         edz;
      int           cyc;
      refModel(ta, tb_, eq, er, edz);
      cal = 1'b1;
      a   = ta;
      b   = tb_;
      #1;
      checkOutput("rdy_masked", rdy, 0);
      @(posedge clk);
      #1;
      cal = 1'b0;
      a   = W'($urandom);
      b   = W'($urandom);
      waitResult(cyc);
      checkOutput("latency", cyc, LAT);
      checkOutput("q", q, eq);
      checkOutput("r", r, er);
      checkOutput("dz", dz, edz);
      prev_q = q;
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           cyc;
      total  = 0;
      bad    = 0;
      prev_q = '0;
      rst    = 1'b1;
      cal    = 1'b0;
      a      = '0;
      b      = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_q", q, 0);
      checkOutput("rst_r", r, 0);
      checkOutput("rst_dz", dz, 0);
      checkOutput("rst_rdy", rdy, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] directed cases");
      applyStimulus(8'd200, 8'd7);
      applyStimulus(8'd5, 8'd0);
      applyStimulus(8'd9, 8'd3);
      applyStimulus(8'd255, 8'd255);
      applyStimulus(8'd3, 8'd10);
      applyStimulus(8'd255, 8'd1);
      applyStimulus(8'd0, 8'd5);
`ifdef DIV_SIGNED_EN
      applyStimulus(8'hF9, 8'd2);
      applyStimulus(8'h80, 8'hFF);
      applyStimulus(8'h80, 8'h00);
      applyStimulus(8'd7, 8'hFE);
`endif

      $display("[TB] cal held during calculation");
      cal = 1'b1;
      a   = 8'd100;
      b   = 8'd9;
      @(posedge clk);
      #1;
      a = 8'd1;
      b = 8'd1;
      repeat (LAT) @(posedge clk);
      #1;
      checkOutput("held_first_q", q, 11);
      checkOutput("held_first_r", r, 1);
      checkOutput("held_rdy_masked", rdy, 0);
      prev_q = q;
      @(posedge clk);
      #1;
      cal = 1'b0;
      waitResult(cyc);
      checkOutput("held_latency", cyc, LAT);
      checkOutput("held_second_q", q, 1);
      checkOutput("held_second_r", r, 0);
      prev_q = q;
      @(posedge clk);
      #1;

      $display("[TB] reset during calculation");
      cal = 1'b1;
      a   = 8'd200;
      b   = 8'd7;
      @(posedge clk);
      #1;
      cal = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midrst_q", q, 0);
      checkOutput("midrst_r", r, 0);
      checkOutput("midrst_rdy", rdy, 0);
      rst    = 1'b0;
      prev_q = '0;
      @(posedge clk);
      #1;
      checkOutput("midrst_idle_rdy", rdy, 0);
      applyStimulus(8'd50, 8'd5);

      $display("[TB] randomized operands");
      for (int i = 0; i < 150; i++) begin
         ra = W'($urandom);
         case ($urandom_range(0, 7))
            0:       rb = '0;
            1:       rb = W'($urandom_range(1, 3));
            2:       rb = ra;
            default: rb = W'($urandom);
         endcase
         applyStimulus(ra, rb);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
